// File: rtl/pacman_pkg.sv
// Shared types and keyboard decode for the Pac-Man wall guard.
package pacman_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        COMMIT = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_req_t;

    // Maps a USB keycode to a heading request; unknown keys are flagged invalid.
    function automatic key_req_t key2dir(input logic [7:0] key);
        key_req_t r;
        r.valid = 1'b1;
        r.dir   = UP;
        case (key)
            KEY_W:   r.dir = UP;
            KEY_S:   r.dir = DOWN;
            KEY_A:   r.dir = LEFT;
            KEY_D:   r.dir = RIGHT;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pacman_wall_guard_probe.sv
// Flags a wall pixel landing inside one rectangular probe strip (inclusive, signed bounds).
module pac_probe_strip (
    input  logic signed [10:0] x_lo,
    input  logic signed [10:0] x_hi,
    input  logic signed [10:0] y_lo,
    input  logic signed [10:0] y_hi,
    input  logic        [9:0]  DrawX,
    input  logic        [9:0]  DrawY,
    input  logic               wall_on,
    output logic               hit
);

    logic signed [10:0] px;
    logic signed [10:0] py;

    assign px = signed'({1'b0, DrawX});
    assign py = signed'({1'b0, DrawY});

    // Raster pixel is a wall and falls within the strip rectangle.
    always_comb begin
        hit = wall_on && (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi);
    end

endmodule

// File: rtl/pacman_wall_guard.sv
// Pac-Man movement guard: probes the raster around Pac-Man each frame and only
// steps into directions whose probe strip stayed wall-free for the whole frame.
module pacman_wall_guard
    import pacman_pkg::*;
#(
    parameter logic [9:0] START_X = 10'd60,
    parameter logic [9:0] START_Y = 10'd60,
    parameter logic [9:0] RADIUS  = 10'd8,
    parameter logic [9:0] STEP    = 10'd1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       wall_on,
    input  logic [7:0] keycode,
    output logic [9:0] PacX,
    output logic [9:0] PacY,
    output logic [1:0] dir,
    output logic       moving,
    output logic [3:0] blocked
);

    localparam logic signed [10:0] R_S     = signed'({1'b0, RADIUS});
    localparam logic signed [10:0] STEP_S  = signed'({1'b0, STEP});
    localparam logic        [9:0]  MIN_POS = RADIUS + STEP;
    localparam logic        [9:0]  MAX_X   = 10'd639 - RADIUS - STEP;
    localparam logic        [9:0]  MAX_Y   = 10'd479 - RADIUS - STEP;
    localparam logic signed [10:0] MIN_S   = signed'({1'b0, MIN_POS});
    localparam logic signed [10:0] MAX_X_S = signed'({1'b0, MAX_X});
    localparam logic signed [10:0] MAX_Y_S = signed'({1'b0, MAX_Y});

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d, nd;
    logic [9:0] pos_x, pos_y, pos_x_d, pos_y_d;
    logic [3:0] hit_q, hit_d, blocked_q, blocked_d, hit_now;
    logic       primed_q, primed_d, moving_q, moving_d;
    logic       fc_q, fedge, clamp_hit;
    key_req_t   req;

    logic signed [10:0] px_s, py_s, cand_x, cand_y;
    logic signed [10:0] x_lo [4];
    logic signed [10:0] x_hi [4];
    logic signed [10:0] y_lo [4];
    logic signed [10:0] y_hi [4];

    assign px_s    = signed'({1'b0, pos_x});
    assign py_s    = signed'({1'b0, pos_y});
    assign fedge   = frame_clk & ~fc_q;
    assign PacX    = pos_x;
    assign PacY    = pos_y;
    assign dir     = dir_q;
    assign moving  = moving_q;
    assign blocked = blocked_q;

    // STEP-deep strips hugging each side of the Pac-Man box.
    always_comb begin
        x_lo[UP]    = px_s - R_S;            x_hi[UP]    = px_s + R_S;
        y_lo[UP]    = py_s - R_S - STEP_S;   y_hi[UP]    = py_s - R_S - 11'sd1;
        x_lo[DOWN]  = px_s - R_S;            x_hi[DOWN]  = px_s + R_S;
        y_lo[DOWN]  = py_s + R_S + 11'sd1;   y_hi[DOWN]  = py_s + R_S + STEP_S;
        x_lo[LEFT]  = px_s - R_S - STEP_S;   x_hi[LEFT]  = px_s - R_S - 11'sd1;
        y_lo[LEFT]  = py_s - R_S;            y_hi[LEFT]  = py_s + R_S;
        x_lo[RIGHT] = px_s + R_S + 11'sd1;   x_hi[RIGHT] = px_s + R_S + STEP_S;
        y_lo[RIGHT] = py_s - R_S;            y_hi[RIGHT] = py_s + R_S;
    end

    for (genvar g = 0; g < 4; g++) begin : g_probe
        pac_probe_strip u_probe (
            .x_lo    (x_lo[g]),
            .x_hi    (x_hi[g]),
            .y_lo    (y_lo[g]),
            .y_hi    (y_hi[g]),
            .DrawX   (DrawX),
            .DrawY   (DrawY),
            .wall_on (wall_on),
            .hit     (hit_now[g])
        );
    end

    // State, position and flag registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= SCAN;
            fc_q      <= 1'b0;
            pos_x     <= START_X;
            pos_y     <= START_Y;
            dir_q     <= RIGHT;
            moving_q  <= 1'b0;
            blocked_q <= '0;
            hit_q     <= '0;
            primed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fc_q      <= frame_clk;
            pos_x     <= pos_x_d;
            pos_y     <= pos_y_d;
            dir_q     <= dir_d;
            moving_q  <= moving_d;
            blocked_q <= blocked_d;
            hit_q     <= hit_d;
            primed_q  <= primed_d;
        end
    end

    // Scan/commit/update sequencing, turn arbitration and clamped move.
    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x;
        pos_y_d   = pos_y;
        dir_d     = dir_q;
        moving_d  = moving_q;
        blocked_d = blocked_q;
        hit_d     = hit_q;
        primed_d  = primed_q;
        req       = key2dir(keycode);
        nd        = dir_q;
        cand_x    = px_s;
        cand_y    = py_s;
        clamp_hit = 1'b0;
        case (state_q)
            SCAN: begin
                hit_d = hit_q | hit_now;
                if (fedge) state_d = COMMIT;
            end
            COMMIT: begin
                // hit_now folded in so a wall seen in this very cycle still counts
                blocked_d = hit_q | hit_now;
                hit_d     = '0;
                state_d   = UPDATE;
            end
            UPDATE: begin
                state_d = SCAN;
                if (!primed_q) begin
                    primed_d = 1'b1;
                    moving_d = 1'b0;
                end else begin
                    if (req.valid && !blocked_q[req.dir]) nd = req.dir;
                    dir_d = nd;
                    if (blocked_q[nd]) begin
                        moving_d = 1'b0;
                    end else begin
                        case (nd)
                            UP:      cand_y = py_s - STEP_S;
                            DOWN:    cand_y = py_s + STEP_S;
                            LEFT:    cand_x = px_s - STEP_S;
                            default: cand_x = px_s + STEP_S;
                        endcase
                        if (cand_x < MIN_S) begin
                            pos_x_d = MIN_POS; clamp_hit = 1'b1;
                        end else if (cand_x > MAX_X_S) begin
                            pos_x_d = MAX_X;   clamp_hit = 1'b1;
                        end else begin
                            pos_x_d = cand_x[9:0];
                        end
                        if (cand_y < MIN_S) begin
                            pos_y_d = MIN_POS; clamp_hit = 1'b1;
                        end else if (cand_y > MAX_Y_S) begin
                            pos_y_d = MAX_Y;   clamp_hit = 1'b1;
                        end else begin
                            pos_y_d = cand_y[9:0];
                        end
                        moving_d = !clamp_hit;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

endmodule

// File: tb/tb_pacman_wall_guard.sv
// Randomized bench for pacman_wall_guard against a pixel-level behavioural model.
module tb_pacman_wall_guard;

    localparam int R = 8, STEP = 1, SX = 60, SY = 60;

    logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, wall_on = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic [7:0] keycode = '0;
    logic [9:0] PacX, PacY;
    logic [1:0] dir;
    logic       moving;
    logic [3:0] blocked;

    int n_tests = 0, n_fail = 0;
    int m_x, m_y, m_dir;
    bit m_moving, m_primed, walls_en;
    bit [3:0] m_blk, m_acc;
    bit [7:0] keys [6] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h00, 8'h55};

    pacman_wall_guard #(
        .START_X (10'd60),
        .START_Y (10'd60),
        .RADIUS  (10'd8),
        .STEP    (10'd1)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .wall_on   (wall_on),
        .keycode   (keycode),
        .PacX      (PacX),
        .PacY      (PacY),
        .dir       (dir),
        .moving    (moving),
        .blocked   (blocked)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit wall_at(input int x, input int y);
        return walls_en && (x <= 25 || y <= 25 || x >= 614 || y >= 454);
    endfunction

    function automatic bit in_strip(input int d, input int x, input int y);
        case (d)
            0: return x >= m_x - R && x <= m_x + R && y >= m_y - R - STEP && y <= m_y - R - 1;
            1: return x >= m_x - R && x <= m_x + R && y >= m_y + R + 1 && y <= m_y + R + STEP;
            2: return y >= m_y - R && y <= m_y + R && x >= m_x - R - STEP && x <= m_x - R - 1;
            default: return y >= m_y - R && y <= m_y + R && x >= m_x + R + 1 && x <= m_x + R + STEP;
        endcase
    endfunction

    function automatic int key_dir(input bit [7:0] k);
        case (k)
            8'h1A:   return 0;
            8'h16:   return 1;
            8'h04:   return 2;
            8'h07:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic drive_pix(input int x, input int y, input bit w, input bit counted);
        DrawX   = x[9:0];
        DrawY   = y[9:0];
        wall_on = w;
        if (counted && w)
            for (int d = 0; d < 4; d++)
                if (in_strip(d, x, y)) m_acc[d] = 1'b1;
    endtask

    task automatic rand_pix(input int noise, input bit counted);
        int x, y;
        x = m_x - R - STEP - 2 + int'($urandom_range(0, 2 * (R + STEP + 2)));
        y = m_y - R - STEP - 2 + int'($urandom_range(0, 2 * (R + STEP + 2)));
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        drive_pix(x, y, wall_at(x, y) || (int'($urandom_range(0, 999)) < noise), counted);
    endtask

    task automatic model_reset();
        m_x = SX; m_y = SY; m_dir = 3; m_moving = 0; m_primed = 0; m_blk = '0; m_acc = '0;
    endtask

    task automatic model_update();
        int req, nx, ny, lo, hix, hiy;
        m_blk = m_acc;
        m_acc = '0;
        if (!m_primed) begin
            m_primed = 1;
            m_moving = 0;
        end else begin
            req = key_dir(keycode);
            if (req >= 0 && !m_blk[req]) m_dir = req;
            if (m_blk[m_dir]) begin
                m_moving = 0;
            end else begin
                nx = m_x + (m_dir == 3 ? STEP : 0) - (m_dir == 2 ? STEP : 0);
                ny = m_y + (m_dir == 1 ? STEP : 0) - (m_dir == 0 ? STEP : 0);
                lo = R + STEP; hix = 639 - R - STEP; hiy = 479 - R - STEP;
                m_moving = (nx >= lo && nx <= hix && ny >= lo && ny <= hiy);
                m_x = nx < lo ? lo : (nx > hix ? hix : nx);
                m_y = ny < lo ? lo : (ny > hiy ? hiy : ny);
            end
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, "_pac_x"},   int'(PacX),    m_x);
        check({ph, "_pac_y"},   int'(PacY),    m_y);
        check({ph, "_dir"},     int'(dir),     m_dir);
        check({ph, "_moving"},  int'(moving),  int'(m_moving));
        check({ph, "_blocked"}, int'(blocked), int'(m_blk));
    endtask

    task automatic do_reset();
        Reset_n = 0; frame_clk = 0; wall_on = 0; keycode = '0;
        repeat (2) tick();
        model_reset();
        check_all("reset");
        Reset_n = 1;
    endtask

    // Strip sweep plus random window pixels, all in SCAN.
    task automatic scan_pixels(input int noise);
        int x, y;
        for (int d = 0; d < 4; d++)
            for (int a = -R; a <= R; a++)
                for (int k = 1; k <= STEP; k++) begin
                    case (d)
                        0: begin x = m_x + a; y = m_y - R - k; end
                        1: begin x = m_x + a; y = m_y + R + k; end
                        2: begin x = m_x - R - k; y = m_y + a; end
                        default: begin x = m_x + R + k; y = m_y + a; end
                    endcase
                    drive_pix(x, y, wall_at(x, y) || (int'($urandom_range(0, 999)) < noise), 1);
                    tick();
                end
        for (int i = 0; i < 16; i++) begin
            rand_pix(noise, 1);
            tick();
        end
    endtask

    task automatic run_frame(input bit [7:0] key, input int noise, input bit fedge_hit, input string ph);
        keycode = key;
        scan_pixels(noise);
        frame_clk = 1;
        if (fedge_hit) drive_pix(m_x, m_y - R - 1, 1, 1);
        else           rand_pix(300, 1);
        tick();
        rand_pix(300, 1);
        tick();
        drive_pix(m_x + R + 1, m_y, 1, 0);
        tick();
        model_update();
        check_all(ph);
        frame_clk = 0;
        wall_on   = 0;
    endtask

    initial begin
        walls_en = 1;
        do_reset();
        run_frame(8'h00, 0, 0, "prime");

        repeat (28) run_frame(8'h1A, 0, 0, "up");
        check("up_stop_y", int'(PacY), 34);
        check("up_blocked0", int'(blocked[0]), 1);
        check("up_moving", int'(moving), 0);

        repeat (5) run_frame(8'h07, 0, 0, "right");
        repeat (3) run_frame(8'h1A, 0, 0, "refuse");
        check("refuse_dir", int'(dir), 3);

        do_reset();
        run_frame(8'h00, 0, 0, "prime");
        repeat (30) run_frame(8'h04, 0, 0, "left");
        check("left_stop_x", int'(PacX), 34);
        check("left_dir", int'(dir), 2);
        check("left_blocked2", int'(blocked[2]), 1);

        do_reset();
        run_frame(8'h00, 0, 0, "prime");
        run_frame(8'h1A, 0, 1, "fedge_hit");
        check("fedge_blocked0", int'(blocked[0]), 1);
        check("fedge_pac_y", int'(PacY), 60);

        do_reset();
        run_frame(8'h00, 0, 0, "prime");
        repeat (40) run_frame(8'h07, 0, 0, "to100");
        check("to100_x", int'(PacX), 100);
        keycode = 8'h07;
        scan_pixels(0);
        frame_clk = 1;
        tick();
        Reset_n = 0; frame_clk = 0; wall_on = 0;
        tick();
        model_reset();
        check_all("midreset");
        Reset_n = 1;
        run_frame(8'h07, 0, 0, "post_reset");
        check("post_reset_x", int'(PacX), 60);

        walls_en = 0;
        do_reset();
        run_frame(8'h00, 0, 0, "prime");
        repeat (55) run_frame(8'h04, 0, 0, "clamp");
        check("clamp_x", int'(PacX), 9);
        check("clamp_moving", int'(moving), 0);

        walls_en = 1;
        do_reset();
        run_frame(8'h00, 0, 0, "prime");
        repeat (60) run_frame(keys[$urandom_range(0, 5)], 30, ($urandom_range(0, 7) == 0), "rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
